// File: rtl/mxint_cast_pkg.sv
// rtl/mxint_cast_pkg.sv - shared widths and types for the MxInt cast pipeline
package mxint_cast_pkg;

  // Width of the leading-one index: one extra bit so it never wraps.
  function automatic int lz_w(input int man_w);
    return $clog2(man_w) + 1;
  endfunction

  // Signed width wide enough for e_in + L - IN_MAN_WIDTH + 2 without overflow.
  function automatic int exp_calc_w(input int exp_w, input int man_w);
    return exp_w + $clog2(man_w) + 2;
  endfunction

  // Classification of the recomputed shared exponent in stage 2.
  typedef enum logic [1:0] {
    EXP_NORMAL    = 2'd0,
    EXP_UNDERFLOW = 2'd1,
    EXP_OVERFLOW  = 2'd2,
    EXP_ZERO_BLK  = 2'd3
  } exp_class_t;

endpackage

// File: rtl/mxint_leading_one_detector.sv
// rtl/mxint_leading_one_detector.sv - combinational leading-one index with zero flag
module mxint_leading_one_detector #(
  parameter int W     = 16,
  parameter int IDX_W = $clog2(W) + 1
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             zero_o
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < W; i++) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign zero_o = ~|vec_i;

endmodule

// File: rtl/mxint_cast_pipelined.sv
// rtl/mxint_cast_pipelined.sv - two-stage renormalising cast from wide to narrow MxInt
module mxint_cast_pipelined
  import mxint_cast_pkg::*;
#(
  parameter int IN_MAN_WIDTH  = 16,
  parameter int IN_EXP_WIDTH  = 8,
  parameter int OUT_MAN_WIDTH = 8,
  parameter int OUT_EXP_WIDTH = 8,
  parameter int BLOCK_SIZE    = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [BLOCK_SIZE-1:0][IN_MAN_WIDTH-1:0]  mdata_in_0,
  input  logic [IN_EXP_WIDTH-1:0]                  edata_in_0,
  input  logic                                     data_in_0_valid,
  output logic                                     data_in_0_ready,
  output logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0] mdata_out_0,
  output logic [OUT_EXP_WIDTH-1:0]                 edata_out_0,
  output logic                                     data_out_0_valid,
  input  logic                                     data_out_0_ready
);

  localparam int MAG_W      = IN_MAN_WIDTH;
  localparam int LZ_W       = lz_w(IN_MAN_WIDTH);
  localparam int SH_W       = LZ_W + 1;
  localparam int EXP_CALC_W = exp_calc_w(IN_EXP_WIDTH, IN_MAN_WIDTH);

  localparam logic [SH_W-1:0]          SHIFT_REF = SH_W'(OUT_MAN_WIDTH - 2);
  localparam logic [EXP_CALC_W-1:0]    EXP_BIAS  = EXP_CALC_W'(IN_MAN_WIDTH - 2);
  localparam logic [EXP_CALC_W-1:0]    EXP_MAX   = EXP_CALC_W'((64'd1 << OUT_EXP_WIDTH) - 64'd1);
  localparam logic [MAG_W:0]           RND_LIMIT = (MAG_W + 1)'(64'd1 << (OUT_MAN_WIDTH - 1));
  localparam logic [OUT_MAN_WIDTH-1:0] MAN_MAX   = {1'b0, {(OUT_MAN_WIDTH - 1){1'b1}}};
  localparam logic [OUT_MAN_WIDTH-1:0] MAN_MIN   = {1'b1, {(OUT_MAN_WIDTH - 1){1'b0}}};

  typedef struct packed {
    logic [BLOCK_SIZE-1:0][IN_MAN_WIDTH-1:0] man;
    logic [LZ_W-1:0]                         lead;
    logic                                    zero;
    logic [IN_EXP_WIDTH-1:0]                 expo;
  } s1_payload_t;

  // Magnitude kept unsigned at full width so the most negative mantissa fits.
  function automatic logic [MAG_W-1:0] abs_man(input logic [IN_MAN_WIDTH-1:0] m);
    return m[IN_MAN_WIDTH-1] ? (~m + 1'b1) : m;
  endfunction

  // Sign-magnitude shift: right shifts round half away from zero, left shifts are exact.
  function automatic logic [OUT_MAN_WIDTH-1:0] round_lane(input logic [IN_MAN_WIDTH-1:0] m,
                                                          input logic [SH_W-1:0]         sh);
    logic [MAG_W-1:0] mag;
    logic [MAG_W:0]   rmag;
    logic             rbit;
    mag = abs_man(m);
    if (!sh[SH_W-1] && (sh != '0)) begin
      rbit = |(mag & (MAG_W'(1) << (sh - 1'b1)));
      rmag = {1'b0, mag >> sh} + {{MAG_W{1'b0}}, rbit};
    end else begin
      rbit = 1'b0;
      rmag = {1'b0, mag} << (~sh + 1'b1);
    end
    if (m[IN_MAN_WIDTH-1]) return OUT_MAN_WIDTH'(~rmag + 1'b1);
    if (rmag >= RND_LIMIT) return MAN_MAX;
    return OUT_MAN_WIDTH'(rmag);
  endfunction

  logic                                     v1_q, v2_q, adv1, adv2;
  logic [MAG_W-1:0]                         mag_or;
  logic [LZ_W-1:0]                          lead_in;
  logic                                     zero_in;
  s1_payload_t                              s1_d, s1_q;
  logic [SH_W-1:0]                          shamt;
  logic [EXP_CALC_W-1:0]                    e_raw;
  exp_class_t                               e_class;
  logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0] mo_d, mo_q;
  logic [OUT_EXP_WIDTH-1:0]                 eo_d, eo_q;

  assign adv2            = !v2_q || data_out_0_ready;
  assign adv1            = !v1_q || adv2;
  assign data_in_0_ready = adv1;

  // OR of all magnitudes: its leading one is the block's leading one.
  always_comb begin
    mag_or = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) mag_or = mag_or | abs_man(mdata_in_0[i]);
  end

  mxint_leading_one_detector #(
    .W     (MAG_W),
    .IDX_W (LZ_W)
  ) u_lod (
    .vec_i  (mag_or),
    .idx_o  (lead_in),
    .zero_o (zero_in)
  );

  assign s1_d = '{man: mdata_in_0, lead: lead_in, zero: zero_in, expo: edata_in_0};

  // Stage 1 captures the block and its leading-one position on input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      s1_q <= '0;
    end else begin
      if (adv1) v1_q <= data_in_0_valid;
      if (adv1 && data_in_0_valid) s1_q <= s1_d;
    end
  end

  assign shamt = SH_W'(s1_q.lead) - SHIFT_REF;
  assign e_raw = EXP_CALC_W'(s1_q.expo) + EXP_CALC_W'(s1_q.lead) - EXP_BIAS;

  // Decide whether the block is normal, zero, or clamps on the exponent range.
  always_comb begin
    e_class = EXP_NORMAL;
    if (s1_q.zero)                e_class = EXP_ZERO_BLK;
    else if (e_raw[EXP_CALC_W-1]) e_class = EXP_UNDERFLOW;
    else if (e_raw > EXP_MAX)     e_class = EXP_OVERFLOW;
  end

  // Stage-2 results: rounded mantissas, or flush / saturate on exponent range faults.
  always_comb begin
    mo_d = '0;
    eo_d = '0;
    case (e_class)
      EXP_NORMAL: begin
        eo_d = OUT_EXP_WIDTH'(e_raw);
        for (int i = 0; i < BLOCK_SIZE; i++) mo_d[i] = round_lane(s1_q.man[i], shamt);
      end
      EXP_OVERFLOW: begin
        eo_d = '1;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
          if (s1_q.man[i] != '0) mo_d[i] = s1_q.man[i][IN_MAN_WIDTH-1] ? MAN_MIN : MAN_MAX;
        end
      end
      default: ;
    endcase
  end

  // Stage 2 holds the output block; it only moves when downstream can take it.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q <= 1'b0;
      mo_q <= '0;
      eo_q <= '0;
    end else begin
      if (adv2) v2_q <= v1_q;
      if (adv2 && v1_q) begin
        mo_q <= mo_d;
        eo_q <= eo_d;
      end
    end
  end

  assign mdata_out_0      = mo_q;
  assign edata_out_0      = eo_q;
  assign data_out_0_valid = v2_q;

endmodule

// File: tb/tb_mxint_cast_pipelined.sv
// tb/tb_mxint_cast_pipelined.sv - directed vector bench for mxint_cast_pipelined
module tb_mxint_cast_pipelined;

  localparam int IMW = 16;
  localparam int IEW = 8;
  localparam int OMW = 8;
  localparam int OEW = 8;
  localparam int BS  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [BS-1:0][IMW-1:0]  mdata_in_0;
  logic [IEW-1:0]          edata_in_0;
  logic                    data_in_0_valid;
  logic                    data_in_0_ready;
  logic [BS-1:0][OMW-1:0]  mdata_out_0;
  logic [OEW-1:0]          edata_out_0;
  logic                    data_out_0_valid;
  logic                    data_out_0_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mxint_cast_pipelined #(
    .IN_MAN_WIDTH  (IMW),
    .IN_EXP_WIDTH  (IEW),
    .OUT_MAN_WIDTH (OMW),
    .OUT_EXP_WIDTH (OEW),
    .BLOCK_SIZE    (BS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mdata_in_0       (mdata_in_0),
    .edata_in_0       (edata_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .mdata_out_0      (mdata_out_0),
    .edata_out_0      (edata_out_0),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready)
  );

  typedef struct {
    string                  name;
    logic [BS-1:0][IMW-1:0] m;
    logic [IEW-1:0]         e;
    logic [BS-1:0][OMW-1:0] em;
    logic [OEW-1:0]         ee;
  } vec_t;

  vec_t vq[$];

  function automatic logic [BS-1:0][IMW-1:0] pk_in(input int a, input int b, input int c, input int d);
    logic [BS-1:0][IMW-1:0] r;
    r[0] = IMW'(a); r[1] = IMW'(b); r[2] = IMW'(c); r[3] = IMW'(d);
    return r;
  endfunction

  function automatic logic [BS-1:0][OMW-1:0] pk_out(input int a, input int b, input int c, input int d);
    logic [BS-1:0][OMW-1:0] r;
    r[0] = OMW'(a); r[1] = OMW'(b); r[2] = OMW'(c); r[3] = OMW'(d);
    return r;
  endfunction

  task automatic add_vec(input string n, input int a, input int b, input int c, input int d, input int e,
                         input int x, input int y, input int z, input int w, input int ee);
    vec_t v;
    v.name = n;
    v.m    = pk_in(a, b, c, d);
    v.e    = IEW'(e);
    v.em   = pk_out(x, y, z, w);
    v.ee   = OEW'(ee);
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one block into an empty pipe, check it emerges exactly two edges later.
  task automatic run_vec(input vec_t v);
    mdata_in_0       = v.m;
    edata_in_0       = v.e;
    data_in_0_valid  = 1'b1;
    data_out_0_ready = 1'b1;
    #1;
    chk({v.name, "_in_ready"}, 64'(data_in_0_ready), 64'd1);
    step();
    data_in_0_valid = 1'b0;
    chk({v.name, "_early_valid"}, 64'(data_out_0_valid), 64'd0);
    step();
    chk({v.name, "_valid"}, 64'(data_out_0_valid), 64'd1);
    chk({v.name, "_man"}, 64'(mdata_out_0), 64'(v.em));
    chk({v.name, "_exp"}, 64'(edata_out_0), 64'(v.ee));
    step();
    chk({v.name, "_drained"}, 64'(data_out_0_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit                      ready_pat[4];
    int                      sent, rx, cyc;
    bit                      mv1, mv2, exp_rdy, adv1_m, adv2_m, stalled;
    bit                      fire_in;
    logic [BS-1:0][OMW-1:0]  prev_m;
    logic [OEW-1:0]          prev_e;

    ready_pat[0] = 1'b1; ready_pat[1] = 1'b0; ready_pat[2] = 1'b0; ready_pat[3] = 1'b1;

    add_vec("rshift",    256,   -128, 1, 0, 20,  64,  -32, 0, 0, 14);
    add_vec("lshift",    3,     0,    0, 0, 20,  96,  0,   0, 0, 7);
    add_vec("round_sat", 255,   -255, 2, 3, 10,  127, -128, 1, 2, 3);
    add_vec("neg_min",   -32768, 0,   0, 0, 100, -64, 0,   0, 0, 101);
    add_vec("zero_blk",  0,     0,    0, 0, 50,  0,   0,   0, 0, 0);
    add_vec("underflow", 3,     0,    0, 0, 10,  0,   0,   0, 0, 0);
    add_vec("overflow",  -32768, 1,   0, 0, 255, -128, 127, 0, 0, 255);
    add_vec("neg_one",   -1,    0,    0, 0, 20,  -64, 0,   0, 0, 6);
    add_vec("neg_tie",   -386,  -385, 2, 1, 20,  -97, -96, 1, 0, 14);

    rst              = 1'b1;
    mdata_in_0       = '0;
    edata_in_0       = '0;
    data_in_0_valid  = 1'b0;
    data_out_0_ready = 1'b0;
    step();
    step();
    chk("reset_valid", 64'(data_out_0_valid), 64'd0);
    chk("reset_man", 64'(mdata_out_0), 64'd0);
    chk("reset_exp", 64'(edata_out_0), 64'd0);
    chk("reset_in_ready", 64'(data_in_0_ready), 64'd1);
    rst = 1'b0;
    step();

    foreach (vq[i]) run_vec(vq[i]);

    // Backpressure: 8 back-to-back blocks against a 1,0,0,1 ready pattern.
    sent = 0; rx = 0; mv1 = 1'b0; mv2 = 1'b0; stalled = 1'b0;
    prev_m = '0; prev_e = '0;
    mdata_in_0       = pk_in(64, 0, 0, 0);
    edata_in_0       = IEW'(20);
    data_in_0_valid  = 1'b1;
    data_out_0_ready = ready_pat[0];
    for (cyc = 0; cyc < 200 && rx < 8; cyc++) begin
      @(negedge clk);
      exp_rdy = !(mv1 && mv2 && !data_out_0_ready);
      chk("bp_in_ready", 64'(data_in_0_ready), 64'(exp_rdy));
      chk("bp_out_valid", 64'(data_out_0_valid), 64'(mv2));
      if (stalled) begin
        chk("bp_hold_man", 64'(mdata_out_0), 64'(prev_m));
        chk("bp_hold_exp", 64'(edata_out_0), 64'(prev_e));
      end
      if (data_out_0_valid && data_out_0_ready) begin
        chk("bp_man", 64'(mdata_out_0), 64'(pk_out(64, rx, 0, 0)));
        chk("bp_exp", 64'(edata_out_0), 64'(12 + rx));
        rx++;
      end
      stalled = data_out_0_valid && !data_out_0_ready;
      prev_m  = mdata_out_0;
      prev_e  = edata_out_0;
      fire_in = data_in_0_valid && data_in_0_ready;
      adv2_m  = !mv2 || data_out_0_ready;
      adv1_m  = !mv1 || adv2_m;
      if (adv2_m) mv2 = mv1;
      if (adv1_m) mv1 = data_in_0_valid;
      step();
      if (fire_in) sent++;
      data_in_0_valid  = (sent < 8);
      mdata_in_0       = pk_in(64, sent, 0, 0);
      edata_in_0       = IEW'(20 + sent);
      data_out_0_ready = ready_pat[(cyc + 1) % 4];
    end
    chk("bp_received", 64'(rx), 64'd8);
    chk("bp_sent", 64'(sent), 64'd8);
    data_in_0_valid  = 1'b0;
    data_out_0_ready = 1'b1;
    step();
    step();
    chk("bp_no_extra", 64'(data_out_0_valid), 64'd0);

    // Reset with both stages full and the output stalled.
    data_out_0_ready = 1'b0;
    mdata_in_0       = pk_in(256, 0, 0, 0);
    edata_in_0       = IEW'(30);
    data_in_0_valid  = 1'b1;
    step();
    mdata_in_0 = pk_in(3, 0, 0, 0);
    step();
    data_in_0_valid = 1'b0;
    chk("full_out_valid", 64'(data_out_0_valid), 64'd1);
    chk("full_in_ready", 64'(data_in_0_ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 64'(data_out_0_valid), 64'd0);
    chk("midrst_man", 64'(mdata_out_0), 64'd0);
    chk("midrst_exp", 64'(edata_out_0), 64'd0);
    run_vec(vq[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
